// File: rtl/multi_port_fifo.sv
// Multi-lane circular FIFO between fetch/predecode and decode/issue.
// Accepts up to PUSH_PORTS entries and releases up to POP_PORTS entries per
// cycle in program order, using every storage slot (occupancy is tracked by
// an explicit counter, so no slot is sacrificed to tell full from empty).
module multi_port_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int PUSH_PORTS   = 2,
  parameter int POP_PORTS    = 2,
  parameter int AFULL_THRESH = DEPTH - 4,
  parameter int PTR_W        = $clog2(DEPTH),
  parameter int CNT_W        = PTR_W + 1,
  parameter int PN_W         = $clog2(PUSH_PORTS + 1),
  parameter int QN_W         = $clog2(POP_PORTS + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [PN_W-1:0]                  push_num,
  input  logic [PUSH_PORTS*DATA_WIDTH-1:0] push_data,
  output logic                             push_stall,
  input  logic [QN_W-1:0]                  pop_num,
  output logic [POP_PORTS*DATA_WIDTH-1:0]  pop_data,
  output logic [POP_PORTS-1:0]             pop_valid,
  output logic [CNT_W-1:0]                 count,
  output logic                             empty,
  output logic                             full,
  output logic                             almost_full
);

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PUSH_MAX_C = CNT_W'(PUSH_PORTS);
  localparam logic [CNT_W-1:0] POP_MAX_C  = CNT_W'(POP_PORTS);
  localparam logic [CNT_W-1:0] AFULL_C    = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ZERO_C = {PTR_W{1'b0}};

  // Storage deliberately has no reset; pointers and count define validity.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  logic [CNT_W-1:0]      push_req_s;
  logic [CNT_W-1:0]      pop_req_s;
  logic [CNT_W-1:0]      free_s;
  logic [CNT_W-1:0]      push_cnt_s;
  logic [CNT_W-1:0]      pop_cnt_s;
  logic                  push_stall_s;
  logic                  push_ok_s;

  // Clamp requests to the lane count and decide push acceptance / pop amount.
  // Room is judged on the current count only: a same-cycle pop frees nothing.
  always_comb begin
    push_req_s   = (CNT_W'(push_num) > PUSH_MAX_C) ? PUSH_MAX_C : CNT_W'(push_num);
    pop_req_s    = (CNT_W'(pop_num) > POP_MAX_C) ? POP_MAX_C : CNT_W'(pop_num);
    free_s       = DEPTH_C - count_r;
    push_stall_s = (push_req_s > free_s);
    push_ok_s    = !push_stall_s && (push_req_s != CNT_ZERO_C);
    push_cnt_s   = push_ok_s ? push_req_s : CNT_ZERO_C;
    pop_cnt_s    = (pop_req_s > count_r) ? count_r : pop_req_s;
  end

  // Pointer and occupancy state; flush outranks any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= CNT_ZERO_C;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= CNT_ZERO_C;
    end else begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt_s);
      rd_ptr_r <= rd_ptr_r + PTR_W'(pop_cnt_s);
      count_r  <= count_r + push_cnt_s - pop_cnt_s;
    end
  end

  // Write accepted lanes into consecutive slots, wrapping modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst && !flush && push_ok_s) begin
      for (int i = 0; i < PUSH_PORTS; i++) begin
        if (CNT_W'(i) < push_cnt_s) begin
          mem_r[wr_ptr_r + PTR_W'(i)] <= push_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Present the oldest POP_PORTS entries straight from storage (no bypass).
  always_comb begin
    pop_data  = {(POP_PORTS*DATA_WIDTH){1'b0}};
    pop_valid = {POP_PORTS{1'b0}};
    for (int j = 0; j < POP_PORTS; j++) begin
      pop_data[j*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_ptr_r + PTR_W'(j)];
      pop_valid[j] = (count_r > CNT_W'(j));
    end
  end

  assign push_stall  = push_stall_s;
  assign count       = count_r;
  assign empty       = (count_r == CNT_ZERO_C);
  assign full        = (count_r == DEPTH_C);
  assign almost_full = (count_r >= AFULL_C);

endmodule

// File: tb/tb_multi_port_fifo.sv
// Scoreboard bench for multi_port_fifo: the stimulus process keeps a simple
// occupancy model and queues every accepted entry; a monitor process pops the
// queue whenever the DUT hands entries to the consumer and compares data.
module tb_multi_port_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [1:0]    push_num;
  logic [2*DW-1:0] push_data;
  logic          push_stall;
  logic [1:0]    pop_num;
  logic [2*DW-1:0] pop_data;
  logic [1:0]    pop_valid;
  logic [4:0]    count;
  logic          empty;
  logic          full;
  logic          almost_full;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  logic [DW-1:0] exp_q [$];

  multi_port_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .push_num    (push_num),
    .push_data   (push_data),
    .push_stall  (push_stall),
    .pop_num     (pop_num),
    .pop_data    (pop_data),
    .pop_valid   (pop_valid),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, check pre-edge outputs against
  // the model, then advance the model to what the coming edge should do.
  task automatic cycle(input int pn, input int qn, input bit fl,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int pnc;
    int qnc;
    int popped;
    bit stall_e;
    @(negedge clk);
    push_num  = pn[1:0];
    pop_num   = qn[1:0];
    flush     = fl;
    push_data = {d1, d0};
    #2;
    pnc = (pn > 2) ? 2 : pn;
    qnc = (qn > 2) ? 2 : qn;
    stall_e = (pnc > DEPTH - model_cnt);
    chk("push_stall", push_stall, stall_e);
    chk("count", count, model_cnt);
    chk("empty", empty, model_cnt == 0);
    chk("full", full, model_cnt == DEPTH);
    chk("almost_full", almost_full, model_cnt >= 12);
    chk("pop_valid", pop_valid, {model_cnt > 1, model_cnt > 0});
    if (fl) begin
      model_cnt = 0;
      exp_q.delete();
    end else begin
      popped = (qnc < model_cnt) ? qnc : model_cnt;
      if (!stall_e && pnc > 0) begin
        exp_q.push_back(d0);
        if (pnc > 1) exp_q.push_back(d1);
        model_cnt = model_cnt + pnc;
      end
      model_cnt = model_cnt - popped;
    end
  endtask

  // Mid-cycle asynchronous reset: outputs must clear before any clock edge.
  task automatic reset_mid();
    @(negedge clk);
    push_num = 2'd2;
    pop_num  = 2'd0;
    flush    = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_push_stall", push_stall, 0);
    model_cnt = 0;
    exp_q.delete();
    push_num = 2'd0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: take exactly the lanes the consumer accepts and compare in order.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst && !flush) begin
        for (int j = 0; j < 2; j++) begin
          if (j < ((pop_num > 2'd2) ? 2 : int'(pop_num)) && pop_valid[j]) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL pop_underflow lane=%0d actual=%0h required=none", j, pop_data[j*DW +: DW]);
            end else begin
              chk("pop_data", pop_data[j*DW +: DW], exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    push_num = 2'd0;
    pop_num = 2'd0;
    push_data = '0;
    #12;
    rst = 1'b1;

    // Build count=5, then reset asynchronously mid-cycle.
    cycle(2, 0, 0, 32'hA0, 32'hA1);
    cycle(2, 0, 0, 32'hA2, 32'hA3);
    cycle(1, 0, 0, 32'hA4, 32'hA5);
    reset_mid();
    cycle(2, 0, 0, 32'hB0, 32'hB1);
    cycle(0, 2, 0, 32'h0, 32'h0);

    // Fill to full with 0..15, then a stalled single push.
    for (int k = 0; k < 8; k++) cycle(2, 0, 0, 2*k, 2*k + 1);
    cycle(1, 0, 0, 32'hC0, 32'hC1);
    // Full: push rejected, pop still applied -> 14.
    cycle(2, 2, 0, 32'hC2, 32'hC3);
    // At 14: push and pop both applied -> stays 14.
    cycle(2, 2, 0, 32'hC4, 32'hC5);
    cycle(1, 0, 0, 32'hC6, 32'hC7);
    // At 15: push stalls, pop applied -> 13.
    cycle(2, 2, 0, 32'hC8, 32'hC9);
    cycle(0, 2, 0, 32'h0, 32'h0);
    cycle(0, 2, 0, 32'h0, 32'h0);
    // At 9: flush beats push and pop.
    cycle(2, 1, 1, 32'hDEAD, 32'hBEEF);
    // Empty pop is a no-op; same-cycle push is not bypassed.
    cycle(0, 2, 0, 32'h0, 32'h0);
    cycle(1, 1, 0, 32'h5A5A, 32'h0);
    cycle(0, 0, 0, 32'h0, 32'h0);
    cycle(0, 1, 0, 32'h0, 32'h0);

    // Randomised traffic, fill-biased then drain-biased, rare flushes.
    for (int n = 0; n < 600; n++) begin
      int pn;
      int qn;
      bit fl;
      pn = $urandom_range(0, 3);
      qn = (n % 200 < 100) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      fl = ($urandom_range(0, 59) == 0);
      cycle(pn, qn, fl, $urandom, $urandom);
    end
    cycle(0, 0, 0, 32'h0, 32'h0);
    #2;
    chk("final_occupancy", count, exp_q.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
